// File: rtl/pixel_processing_pipe.sv
// Pixel processing pipe: per-lane panel drive generation with INIT/NORMAL/CLEAR
// sequencing and a one-deep valid/ready output register.
module pixel_processing_pipe #(
    parameter int PPC          = 4,
    parameter int FASTM_FRAMES = 10,
    parameter int INIT_FRAMES  = 100,
    parameter int CLEAR_FRAMES = 42
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_end,
    input  logic              clear_req,
    output logic [1:0]        op_state,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [4*PPC-1:0]  p_or,
    input  logic [4*PPC-1:0]  p_od,
    input  logic [4*PPC-1:0]  p_e1,
    input  logic [4*PPC-1:0]  p_e4,
    input  logic [16*PPC-1:0] bi,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [16*PPC-1:0] bo,
    output logic [2*PPC-1:0]  pout
);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_NORMAL = 2'd1;
    localparam logic [1:0] ST_CLEAR  = 2'd2;

    localparam logic [10:0] INIT_LAST  = 11'(INIT_FRAMES - 1);
    localparam logic [10:0] CLEAR_LAST = 11'(CLEAR_FRAMES - 1);
    localparam logic [6:0]  FASTM7     = 7'(FASTM_FRAMES);
    localparam logic [5:0]  FASTM6     = 6'(FASTM_FRAMES);

    logic [1:0]        state;
    logic [10:0]       fc;
    logic [1:0]        seq_drive;
    logic [16*PPC-1:0] bo_nxt;
    logic [2*PPC-1:0]  pout_nxt;
    logic              accept;

    assign op_state = state;
    assign s_ready  = !m_valid || m_ready;
    assign accept   = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            fc    <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (frame_end) begin
                        if (fc == INIT_LAST) begin
                            state <= ST_NORMAL;
                            fc    <= '0;
                        end else begin
                            fc <= fc + 11'd1;
                        end
                    end
                end
                ST_NORMAL: begin
                    fc <= '0;
                    if (clear_req) state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    if (frame_end) begin
                        if (fc == CLEAR_LAST) begin
                            state <= ST_NORMAL;
                            fc    <= '0;
                        end else begin
                            fc <= fc + 11'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_INIT;
                    fc    <= '0;
                end
            endcase
        end
    end

    always_comb begin
        seq_drive = 2'b00;
        if (state == ST_INIT) begin
            if      (fc < 11'd10) seq_drive = 2'b00;
            else if (fc < 11'd54) seq_drive = 2'b01;
            else if (fc < 11'd56) seq_drive = 2'b00;
            else if (fc < 11'd98) seq_drive = 2'b10;
            else                  seq_drive = 2'b00;
        end else if (state == ST_CLEAR) begin
            if      (fc < 11'd20) seq_drive = 2'b01;
            else if (fc < 11'd22) seq_drive = 2'b00;
            else if (fc < 11'd40) seq_drive = 2'b10;
            else                  seq_drive = 2'b00;
        end
    end

    for (genvar k = 0; k < PPC; k++) begin : g_lane
        logic [15:0] b;
        logic [3:0]  vin;
        logic        tgt;
        logic        prev;
        logic [5:0]  cnt;
        logic [6:0]  fm_raw;
        logic [5:0]  fm_sat;
        logic [15:0] bo_l;
        logic [1:0]  po_l;
        logic        unused_vin;

        assign b    = bi[16*k +: 16];
        assign cnt  = b[9:4];
        assign prev = b[0];

        always_comb begin
            case (b[13:12])
                2'b00:   vin = p_or[4*k +: 4];
                2'b01:   vin = p_od[4*k +: 4];
                2'b10:   vin = p_e1[4*k +: 4];
                default: vin = p_e4[4*k +: 4];
            endcase
        end

        assign tgt        = vin[3];
        assign unused_vin = ^vin[2:0];

        // Re-arm length wraps in 7 bits for large cnt, so the wrapped value saturates too
        assign fm_raw = FASTM7 - {1'b0, cnt} + 7'd2;
        assign fm_sat = (fm_raw > FASTM7) ? FASTM6 : fm_raw[5:0];

        always_comb begin
            po_l = 2'b00;
            bo_l = b;
            if (state != ST_NORMAL) begin
                po_l = seq_drive;
                bo_l = {2'b01, b[13:12], 2'b00, 6'd0, 4'b0001};
            end else if (b[15:14] == 2'b01) begin
                if (cnt == 6'd0) begin
                    if (tgt != prev) begin
                        po_l = tgt ? 2'b10 : 2'b01;
                        bo_l = {b[15:10], FASTM6, 3'b000, tgt};
                    end
                end else begin
                    po_l = tgt ? 2'b10 : 2'b01;
                    if (tgt == prev) bo_l = {b[15:10], cnt - 6'd1, b[3:0]};
                    else             bo_l = {b[15:10], fm_sat, 3'b000, tgt};
                end
            end
        end

        assign bo_nxt[16*k +: 16]  = bo_l;
        assign pout_nxt[2*k +: 2]  = po_l;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            bo      <= '0;
            pout    <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            bo      <= bo_nxt;
            pout    <= pout_nxt;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_processing_pipe.sv
// Bench for pixel_processing_pipe: behavioural frame/lane model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_pixel_processing_pipe;

    localparam int PPC   = 4;
    localparam int FASTM = 10;
    localparam int INITF = 100;
    localparam int CLRF  = 42;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_end = 1'b0;
    logic              clear_req = 1'b0;
    logic [1:0]        op_state;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [4*PPC-1:0]  p_or = '0, p_od = '0, p_e1 = '0, p_e4 = '0;
    logic [16*PPC-1:0] bi = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [16*PPC-1:0] bo;
    logic [2*PPC-1:0]  pout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pixel_processing_pipe #(
        .PPC(PPC), .FASTM_FRAMES(FASTM), .INIT_FRAMES(INITF), .CLEAR_FRAMES(CLRF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_end(frame_end), .clear_req(clear_req),
        .op_state(op_state), .s_valid(s_valid), .s_ready(s_ready),
        .p_or(p_or), .p_od(p_od), .p_e1(p_e1), .p_e4(p_e4), .bi(bi),
        .m_valid(m_valid), .m_ready(m_ready), .bo(bo), .pout(pout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int seq_drive(input int st, input int fc);
        if (st == 0) begin
            if (fc >= 10 && fc < 54) return 1;
            if (fc >= 56 && fc < 98) return 2;
            return 0;
        end
        if (fc < 20) return 1;
        if (fc >= 22 && fc < 40) return 2;
        return 0;
    endfunction

    function automatic void lane_model(input int st, input int fc, input logic [15:0] b,
                                       input logic [3:0] por, input logic [3:0] pod,
                                       input logic [3:0] pe1, input logic [3:0] pe4,
                                       output logic [15:0] bo_e, output logic [1:0] po_e);
        int mode = int'(b[15:14]);
        int cnt  = int'(b[9:4]);
        int prev = int'(b[0]);
        int tgt;
        int n;
        case (b[13:12])
            2'b00:   tgt = int'(por[3]);
            2'b01:   tgt = int'(pod[3]);
            2'b10:   tgt = int'(pe1[3]);
            default: tgt = int'(pe4[3]);
        endcase
        if (st != 1) begin
            po_e = 2'(seq_drive(st, fc));
            bo_e = 16'h4001 | {2'b00, b[13:12], 12'h000};
        end else if (mode != 1 || (cnt == 0 && tgt == prev)) begin
            po_e = 2'b00;
            bo_e = b;
        end else begin
            po_e = (tgt != 0) ? 2'b10 : 2'b01;
            if (tgt == prev) begin
                bo_e = {b[15:10], 6'(cnt - 1), b[3:0]};
            end else begin
                n = (FASTM - cnt + 2 + 128) % 128;
                if (n > FASTM) n = FASTM;
                bo_e = {b[15:10], 6'(n), 3'b000, 1'(tgt)};
            end
        end
    endfunction

    // Model state reflects what the DUT should hold after the most recent edge
    int          md_state = 0;
    int          md_fc = 0;
    bit          md_mv = 0;
    logic [15:0] md_bo [PPC];
    logic [1:0]  md_po [PPC];
    bit          md_accept = 0;

    always @(negedge clk) begin
        logic [15:0] be;
        logic [1:0]  pe;
        if (!rst_n) begin
            md_state = 0;
            md_fc = 0;
            md_mv = 0;
            for (int k = 0; k < PPC; k++) begin
                md_bo[k] = '0;
                md_po[k] = '0;
            end
        end
        check("op_state", 64'(op_state), 64'(md_state));
        check("m_valid", 64'(m_valid), 64'(md_mv));
        check("s_ready", 64'(s_ready), 64'(!md_mv || m_ready));
        if (md_mv || !rst_n) begin
            for (int k = 0; k < PPC; k++) begin
                check("lane_bo", 64'(bo[16*k +: 16]), 64'(md_bo[k]));
                check("lane_pout", 64'(pout[2*k +: 2]), 64'(md_po[k]));
            end
        end
        md_accept = 0;
        if (rst_n) begin
            md_accept = s_valid && (!md_mv || m_ready);
            if (md_accept) begin
                for (int k = 0; k < PPC; k++) begin
                    lane_model(md_state, md_fc, bi[16*k +: 16], p_or[4*k +: 4], p_od[4*k +: 4],
                               p_e1[4*k +: 4], p_e4[4*k +: 4], be, pe);
                    md_bo[k] = be;
                    md_po[k] = pe;
                end
                md_mv = 1;
            end else if (m_ready) begin
                md_mv = 0;
            end
            case (md_state)
                0: if (frame_end) begin
                       if (md_fc == INITF - 1) begin md_state = 1; md_fc = 0; end
                       else md_fc++;
                   end
                1: if (clear_req) begin md_state = 2; md_fc = 0; end
                default: if (frame_end) begin
                       if (md_fc == CLRF - 1) begin md_state = 1; md_fc = 0; end
                       else md_fc++;
                   end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input logic [15:0] b, input logic [3:0] por,
                            input logic [3:0] pod, input logic [3:0] pe1, input logic [3:0] pe4);
        bi[16*k +: 16]  = b;
        p_or[4*k +: 4]  = por;
        p_od[4*k +: 4]  = pod;
        p_e1[4*k +: 4]  = pe1;
        p_e4[4*k +: 4]  = pe4;
    endtask

    task automatic rand_lanes();
        for (int k = 0; k < PPC; k++)
            set_lane(k, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic beat();
        s_valid = 1'b1;
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic frame();
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) cyc();
        check("rst_op_state", 64'(op_state), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_bo", 64'(bo), 64'd0);
        check("rst_pout", 64'(pout), 64'd0);
        rst_n = 1'b1;
        cyc();

        for (int f = 0; f < INITF; f++) begin
            rand_lanes();
            beat();
            case (f)
                5, 54, 98:  check("init_drive_00", 64'(pout[1:0]), 64'd0);
                10, 53:     check("init_drive_01", 64'(pout[1:0]), 64'd1);
                56, 97:     check("init_drive_10", 64'(pout[1:0]), 64'd2);
                default: ;
            endcase
            frame();
        end
        check("init_done", 64'(op_state), 64'd1);

        rand_lanes();
        set_lane(0, 16'h4000, 4'h8, 4'h0, 4'h0, 4'h0);
        beat();
        check("fm_start_pout", 64'(pout[1:0]), 64'd2);
        check("fm_start_bo", 64'(bo[15:0]), 64'h40A1);
        set_lane(0, 16'h40A1, 4'h8, 4'h0, 4'h0, 4'h0);
        beat();
        check("fm_dec_bo", 64'(bo[15:0]), 64'h4091);
        check("fm_dec_pout", 64'(pout[1:0]), 64'd2);
        set_lane(0, 16'h4011, 4'h0, 4'hF, 4'hF, 4'hF);
        beat();
        check("fm_sat_pout", 64'(pout[1:0]), 64'd1);
        check("fm_sat_bo", 64'(bo[15:0]), 64'h40A0);
        set_lane(0, 16'h4051, 4'h0, 4'hF, 4'hF, 4'hF);
        beat();
        check("fm_rearm_bo", 64'(bo[15:0]), 64'h4070);
        set_lane(0, 16'h4001, 4'h8, 4'h0, 4'h0, 4'h0);
        beat();
        check("fm_idle_pout", 64'(pout[1:0]), 64'd0);
        check("fm_idle_bo", 64'(bo[15:0]), 64'h4001);
        set_lane(0, 16'h5000, 4'h0, 4'h8, 4'h0, 4'h0);
        beat();
        check("dither_sel_bo", 64'(bo[15:0]), 64'h50A1);

        set_lane(0, 16'h0000, 4'h8, 4'h8, 4'h8, 4'h8);
        set_lane(1, 16'h4000, 4'h8, 4'h8, 4'h8, 4'h8);
        set_lane(2, 16'h8000, 4'h8, 4'h8, 4'h8, 4'h8);
        set_lane(3, 16'hC000, 4'h8, 4'h8, 4'h8, 4'h8);
        beat();
        check("modes_pout", 64'(pout), 64'h08);
        check("modes_bo", 64'(bo), 64'hC000_8000_40A1_0000);

        rand_lanes();
        s_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            m_ready = (c < 3 || c > 5);
            cyc();
            if (c >= 3 && c <= 5) begin
                check("stall_s_ready", 64'(s_ready), 64'd0);
                check("stall_m_valid", 64'(m_valid), 64'd1);
            end
            if (c >= 8) check("stream_m_valid", 64'(m_valid), 64'd1);
            if (md_accept) rand_lanes();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        cyc();
        cyc();
        check("drained_m_valid", 64'(m_valid), 64'd0);

        frame();
        check("normal_frame_hold", 64'(op_state), 64'd1);
        clear_req = 1'b1;
        frame_end = 1'b1;
        cyc();
        clear_req = 1'b0;
        frame_end = 1'b0;
        check("clear_enter", 64'(op_state), 64'd2);
        for (int f = 0; f < CLRF; f++) begin
            rand_lanes();
            if (f == 0) set_lane(0, 16'h7FFF, 4'h0, 4'h0, 4'h0, 4'h0);
            beat();
            case (f)
                0: begin
                    check("clear_drive_01", 64'(pout[1:0]), 64'd1);
                    check("clear_bo", 64'(bo[15:0]), 64'h7001);
                end
                19:     check("clear_drive_01", 64'(pout[1:0]), 64'd1);
                20, 40: check("clear_drive_00", 64'(pout[1:0]), 64'd0);
                22, 39: check("clear_drive_10", 64'(pout[1:0]), 64'd2);
                default: ;
            endcase
            frame();
        end
        check("clear_done", 64'(op_state), 64'd1);

        rand_lanes();
        m_ready = 1'b0;
        s_valid = 1'b1;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 64'(m_valid), 64'd0);
        check("midrst_op_state", 64'(op_state), 64'd0);
        check("midrst_s_ready", 64'(s_ready), 64'd1);
        s_valid = 1'b0;
        m_ready = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        check("init_clear_ignored", 64'(op_state), 64'd0);
        repeat (10) frame();
        rand_lanes();
        beat();
        check("init_fc_after_clear", 64'(pout[1:0]), 64'd1);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_processing_pipe.md
PIXEL_PROCESSING_PIPE -- requirements
Module: pixel_processing_pipe

Interface
REQ-001 SHALL have parameter PPC, default 4: pixel lanes processed per beat.
REQ-002 SHALL have parameter FASTM_FRAMES, default 10: fast-mono drive length in frames (1..63).
REQ-003 SHALL have parameter INIT_FRAMES, default 100, and CLEAR_FRAMES, default 42: sequence lengths in frames.
REQ-004 SHALL have ports, in order: clk in 1, single clock; rst_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: frame_end in 1, end-of-frame pulse; clear_req in 1, in-place clear request pulse; op_state out 2, current operating state.
REQ-006 SHALL have ports: s_valid in 1; s_ready out 1; p_or, p_od, p_e1, p_e4 in 4*PPC, original, ordered-1b, ED-1b and ED-4b pixels; bi in 16*PPC, pixel state from VRAM.
REQ-007 SHALL have ports: m_valid out 1; m_ready in 1; bo out 16*PPC, pixel state to VRAM; pout out 2*PPC, panel drive code.
REQ-008 Lane k SHALL occupy bits [4k+3:4k], [16k+15:16k] and [2k+1:2k] of the respective buses.

Function
REQ-009 op_state encoding SHALL be INIT=0, NORMAL=1, CLEAR=2; an internal 11-bit frame counter fc SHALL be kept.
REQ-010 In INIT, frame_end SHALL increment fc; when frame_end arrives with fc==INIT_FRAMES-1, the block SHALL enter NORMAL with fc=0.
REQ-011 In NORMAL, fc SHALL hold 0; clear_req SHALL enter CLEAR with fc=0, taking priority over a simultaneous frame_end.
REQ-012 In CLEAR, frame_end SHALL increment fc; when frame_end arrives with fc==CLEAR_FRAMES-1, the block SHALL enter NORMAL with fc=0.
REQ-013 clear_req outside NORMAL SHALL be ignored.
REQ-014 INIT drive SHALL be 00 for fc<10, 01 for fc<54, 00 for fc<56, 10 for fc<98, and 00 otherwise.
REQ-015 CLEAR drive SHALL be 01 for fc<20, 00 for fc<22, 10 for fc<40, and 00 otherwise.
REQ-016 Handshake: s_ready = !m_valid || m_ready; a beat SHALL be accepted when s_valid && s_ready.
REQ-017 An accepted beat SHALL appear on bo/pout with m_valid high on the next cycle (latency 1).
REQ-018 m_valid, bo and pout SHALL hold stable while m_valid && !m_ready.
REQ-019 m_valid SHALL drop after a transfer that has no new beat accepted in the same cycle; back-to-back beats SHALL sustain 1 beat/clock.
REQ-020 op_state and fc SHALL be sampled at acceptance; a state change after acceptance SHALL NOT alter a registered beat.
REQ-021 Per-lane fields: mode=bi[15:14], dither=bi[13:12], cnt=bi[9:4] (6-bit), prev=bi[0].
REQ-022 Per-lane vin SHALL be p_or, p_od, p_e1 or p_e4 for dither 00, 01, 10 or 11 respectively; tgt=vin[3].
REQ-023 In INIT and CLEAR, every lane SHALL output pout = sequence drive and bo = {01, bi[13:12], 2'b00, 6'd0, 4'b0001}.
REQ-024 In NORMAL with mode 01 and cnt==0: if tgt==prev, pout SHALL be 00 and bo = bi; otherwise pout = tgt?10:01 and bo = {bi[15:10], FASTM_FRAMES, 3'b000, tgt}.
REQ-025 In NORMAL with mode 01 and cnt!=0, pout SHALL be tgt?10:01.
REQ-026 Under REQ-025, if tgt==prev, bo SHALL be {bi[15:10], cnt-1, bi[3:0]}.
REQ-027 Under REQ-025, if tgt!=prev, bo SHALL be {bi[15:10], min(FASTM_FRAMES-cnt+2, FASTM_FRAMES), 3'b000, tgt}, computed at 7 bits before saturation.
REQ-028 In NORMAL with mode 00, 10 or 11, pout SHALL be 00 and bo SHALL equal bi.
REQ-029 Lanes SHALL be fully independent; no lane SHALL read another lane's data.

Reset
REQ-030 While rst_n is low: op_state=INIT, fc=0, m_valid=0, bo=0, pout=0, s_ready=1.
REQ-031 Reset assertion mid-beat or mid-sequence SHALL discard the beat and restart INIT on release.

Verification
REQ-032 Reset, then 100 frame_end pulses with one beat per frame -> pout 00 at fc=0..9, 01 at fc=10..53, 10 at fc=56..97; op_state=1 after the 100th pulse.
REQ-033 NORMAL, lane bi=16'h4000, dither 00, p_or=4'h8 -> pout=10, bo=16'h40A1; then bi=16'h40A1, p_or=8 -> bo=16'h4091.
REQ-034 NORMAL, bi=16'h4011 (cnt=1, prev=1), p_or=0 -> pout=01, bo=16'h40A0 (saturated); bi=16'h4051 (cnt=5) -> bo=16'h4070.
REQ-035 m_ready held low 3 cycles with s_valid high -> bo/pout stable, s_ready=0, no beat lost or duplicated; streaming afterwards at 1 beat/clock.
REQ-036 clear_req and frame_end asserted in the same NORMAL cycle -> op_state=2, fc=0; 42 frame_end pulses -> op_state=1; clear_req during INIT -> no effect.
REQ-037 PPC=4, lanes with modes 00/01/10/11 in one beat -> only lane 1 drives; lanes 0, 2 and 3 have pout=00 and bo=bi.
